// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_arbiter
// Description : Shares one synchronous single-port RAM between an SPI slave
//               command stream and a host request/grant port. Round-robin or
//               fixed (SPI-first) arbitration. Single outstanding SPI op.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_gnt,
  output logic [7:0] host_rdata,
  output logic       host_rvalid,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       err_ovr
);

  localparam logic       c_OWN_SPI  = 1'b0;
  localparam logic       c_OWN_HOST = 1'b1;
  localparam logic [1:0] c_CMD_WADDR = 2'b00;
  localparam logic [1:0] c_CMD_WRITE = 2'b01;
  localparam logic [1:0] c_CMD_RADDR = 2'b10;
  localparam logic [1:0] c_CMD_READ  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_owner;
  logic       r_last_gnt;
  logic [7:0] r_wr_addr;
  logic [7:0] r_rd_addr;
  logic       r_spi_pend;
  logic       r_spi_we;
  logic [7:0] r_spi_op_addr;
  logic [7:0] r_spi_wdata;

  logic [1:0] w_cmd;
  logic [7:0] w_payload;
  logic       w_rx_accept;
  logic       w_pick_host;

  assign w_cmd       = rx_data[9:8];
  assign w_payload   = rx_data[7:0];
  // A frame is only taken when no SPI operation is still waiting for the RAM.
  assign w_rx_accept = rx_valid && !r_spi_pend;

  // Owner selection for the next access: lone requester wins, ties by mode.
  always_comb begin
    w_pick_host = 1'b0;
    if (host_req && !r_spi_pend) begin
      w_pick_host = 1'b1;
    end else if (host_req && r_spi_pend) begin
      if (RR_EN != 0) begin
        w_pick_host = (r_last_gnt == c_OWN_SPI);
      end else begin
        w_pick_host = 1'b0;
      end
    end
  end

  // SPI command decode: address registers, pending-op capture, overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr     <= 8'h00;
      r_rd_addr     <= 8'h00;
      r_spi_pend    <= 1'b0;
      r_spi_we      <= 1'b0;
      r_spi_op_addr <= 8'h00;
      r_spi_wdata   <= 8'h00;
      err_ovr       <= 1'b0;
    end else begin
      err_ovr <= rx_valid && r_spi_pend;
      // The pending op is consumed in the cycle the RAM sees it.
      if (r_state == ST_ACCESS && r_owner == c_OWN_SPI) begin
        r_spi_pend <= 1'b0;
      end
      if (w_rx_accept) begin
        case (w_cmd)
          c_CMD_WADDR: r_wr_addr <= w_payload;
          c_CMD_RADDR: r_rd_addr <= w_payload;
          c_CMD_WRITE: begin
            r_spi_pend    <= 1'b1;
            r_spi_we      <= 1'b1;
            r_spi_op_addr <= r_wr_addr;
            r_spi_wdata   <= w_payload;
            r_wr_addr     <= r_wr_addr + 8'd1;
          end
          c_CMD_READ: begin
            r_spi_pend    <= 1'b1;
            r_spi_we      <= 1'b0;
            r_spi_op_addr <= r_rd_addr;
            r_spi_wdata   <= w_payload;
            r_rd_addr     <= r_rd_addr + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Access FSM; RAM controls and strobes are registered so they line up
  // with the ACCESS / post-RD_WAIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= c_OWN_SPI;
      r_last_gnt  <= c_OWN_HOST;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 8'h00;
      mem_wdata   <= 8'h00;
      host_gnt    <= 1'b0;
      host_rdata  <= 8'h00;
      host_rvalid <= 1'b0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
    end else begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      host_gnt    <= 1'b0;
      host_rvalid <= 1'b0;
      tx_valid    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_spi_pend || host_req) begin
            r_state <= ST_ACCESS;
            mem_en  <= 1'b1;
            if (w_pick_host) begin
              r_owner    <= c_OWN_HOST;
              r_last_gnt <= c_OWN_HOST;
              mem_we     <= host_we;
              mem_addr   <= host_addr;
              mem_wdata  <= host_wdata;
              host_gnt   <= 1'b1;
            end else begin
              r_owner    <= c_OWN_SPI;
              r_last_gnt <= c_OWN_SPI;
              mem_we     <= r_spi_we;
              mem_addr   <= r_spi_op_addr;
              mem_wdata  <= r_spi_wdata;
            end
          end
        end
        ST_ACCESS: begin
          r_state <= mem_we ? ST_IDLE : ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (r_owner == c_OWN_SPI) begin
            tx_data  <= mem_rdata;
            tx_valid <= 1'b1;
          end else begin
            host_rdata  <= mem_rdata;
            host_rvalid <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_ram_arbiter
// Description : Directed self-checking bench; one round-robin instance and
//               one fixed-priority instance, each with its own RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       host_req, host_req0;
  logic       host_we;
  logic [7:0] host_addr, host_wdata;
  logic       ram_clr;

  logic [7:0] tx_data, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       tx_valid, host_gnt, host_rvalid, mem_en, mem_we, err_ovr;
  logic [7:0] tx_data0, host_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic       tx_valid0, host_gnt0, host_rvalid0, mem_en0, mem_we0, err_ovr0;

  logic [7:0] ram  [256];
  logic [7:0] ram0 [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .host_req(host_req),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_ovr(err_ovr)
  );

  spi_ram_arbiter #(.RR_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .host_req(host_req0),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt0), .host_rdata(host_rdata0), .host_rvalid(host_rvalid0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .err_ovr(err_ovr0)
  );

  // Synchronous RAM models: read data valid the cycle after the enable.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else begin
      if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
    end
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int j = 0; j < 256; j++) ram0[j] <= 8'h00;
    end else begin
      if (mem_en0 && mem_we0) ram0[mem_addr0] <= mem_wdata0;
    end
    if (mem_en0 && !mem_we0) mem_rdata0 <= ram0[mem_addr0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one frame for one cycle; returns in the cycle after sampling.
  task automatic send(input logic [9:0] f);
    rx_data  = f;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  logic seen_strobe;

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0;
    host_req = 1'b0; host_req0 = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0; ram_clr = 1'b1;
    #1;
    check("reset_outputs", {tx_valid, host_gnt, host_rvalid, mem_en, mem_we, err_ovr,
                            tx_data, host_rdata}, 32'h0);
    tick(); tick();
    check("reset_outputs0", {tx_valid0, host_gnt0, host_rvalid0, mem_en0, err_ovr0,
                             mem_addr, mem_wdata}, 32'h0);
    check("reset_addr_regs", {dut.r_wr_addr, dut.r_rd_addr}, 32'h0);
    ram_clr = 1'b0;
    rst_n = 1'b1;
    tick();

    // Write 0xAB to address 5, then read it back over SPI.
    send(10'h005);
    send(10'h1AB);
    tick();
    check("wr_access", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 8'h05, 8'hAB});
    tick();
    check("wr_done_idle", {mem_en, mem_we}, 32'h0);
    send(10'h205);
    send(10'h300);
    tick();
    check("rd_access", {mem_en, mem_we, mem_addr}, {2'b10, 8'h05});
    tick();
    check("rd_no_early_tx", tx_valid, 1'b0);
    tick();
    check("rd_tx_n4", {tx_valid, tx_data}, {1'b1, 8'hAB});
    tick();
    check("tx_one_pulse", tx_valid, 1'b0);
    check("ram5", ram[5], 8'hAB);
    check("rd_addr_inc", dut.r_rd_addr, 8'h06);

    // wr_addr wrap 255 -> 0.
    send(10'h0FF);
    send(10'h111);
    tick(); tick();
    send(10'h122);
    tick(); tick();
    check("ram255", ram[255], 8'h11);
    check("ram0_wrap", ram[0], 8'h22);
    check("wr_addr_wrap", dut.r_wr_addr, 8'h01);

    // Overrun: second frame one cycle after a write frame is dropped.
    send(10'h133);
    send(10'h155);
    check("ovr_pulse", err_ovr, 1'b1);
    check("ovr_access", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 8'h01, 8'h33});
    tick();
    check("ovr_one_pulse", err_ovr, 1'b0);
    tick(); tick(); tick();
    check("ovr_wr_addr", dut.r_wr_addr, 8'h02);
    check("ovr_ram", {ram[1], ram[2]}, {8'h33, 8'h00});

    // Uncontended host write; an address load during it applies at once.
    host_req = 1'b1; host_req0 = 1'b1; host_we = 1'b1;
    host_addr = 8'h10; host_wdata = 8'h5A;
    tick();
    check("host_wr_gnt", {host_gnt, mem_en, mem_we, mem_addr, mem_wdata},
          {3'b111, 8'h10, 8'h5A});
    host_req = 1'b0; host_req0 = 1'b0;
    send(10'h240);
    check("host_gnt_pulse", host_gnt, 1'b0);
    check("load_during_host", dut.r_rd_addr, 8'h40);
    tick();
    check("host_wr_ram", {ram[16], ram0[16]}, {8'h5A, 8'h5A});

    // Fresh reset: first tie goes to SPI on both instances.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send(10'h300);
    host_req = 1'b1; host_req0 = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    tick();
    check("tie1_spi_rr", {mem_en, host_gnt, mem_addr}, {2'b10, 8'h00});
    check("tie1_spi_fixed", {mem_en0, host_gnt0, mem_addr0}, {2'b10, 8'h00});
    tick(); tick();
    check("tie1_tx", {tx_valid, tx_data, tx_valid0, tx_data0}, {1'b1, 8'h22, 1'b1, 8'h22});
    tick();
    check("tie1_host_next", {host_gnt, host_gnt0, mem_addr}, {2'b11, 8'h10});
    host_req = 1'b0; host_req0 = 1'b0;
    tick(); tick();
    check("tie1_host_rd", {host_rvalid, host_rdata, host_rvalid0, host_rdata0},
          {1'b1, 8'h5A, 1'b1, 8'h5A});

    // SPI-only write leaves last grant with SPI.
    send(10'h177);
    tick(); tick();
    check("ram0_77", ram[0], 8'h77);

    // Second tie: round-robin favours host, fixed priority still SPI.
    send(10'h300);
    host_req = 1'b1; host_req0 = 1'b1;
    tick();
    check("tie2_rr_host", {host_gnt, mem_addr}, {1'b1, 8'h10});
    check("tie2_fixed_spi", {host_gnt0, mem_en0, mem_addr0}, {2'b01, 8'h01});
    host_req = 1'b0;
    tick(); tick();
    check("tie2_rr_hrd", {host_rvalid, host_rdata}, {1'b1, 8'h5A});
    check("tie2_fixed_tx", {tx_valid0, tx_data0}, {1'b1, 8'h33});
    tick();
    check("tie2_rr_spi_next", {mem_en, mem_we, mem_addr}, {2'b10, 8'h01});
    check("tie2_fixed_host_next", host_gnt0, 1'b1);
    host_req0 = 1'b0;
    tick(); tick();
    check("tie2_rr_tx", {tx_valid, tx_data}, {1'b1, 8'h33});
    check("tie2_fixed_hrd", {host_rvalid0, host_rdata0}, {1'b1, 8'h5A});

    // Reset while in RD_WAIT: access discarded, registers cleared at once.
    send(10'h300);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("rst_async_addr", {dut.r_wr_addr, dut.r_rd_addr}, 32'h0);
    check("rst_async_out", {tx_valid, host_rvalid, mem_en, host_gnt, err_ovr}, 32'h0);
    tick();
    rst_n = 1'b1;
    seen_strobe = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (tx_valid || host_rvalid || tx_valid0 || host_rvalid0 || mem_en) seen_strobe = 1'b1;
    end
    check("no_strobe_after_rst", seen_strobe, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
